// File: rtl/san_cnt_core.sv
// san_cnt_core: programmable periodic counter with a one-cycle interrupt pulse.
// Software writes a period (LIMIT) through the AXI-Lite write path; the block
// counts clock cycles and pulses EXT_IRQ once every LIMIT cycles.
// Register map (byte address, bit 2 decoded):
//   0x0 LIMIT : period in cycles, 0 stops the counter
//   0x4 CTRL  : bit0 = 1 restart from 0 (if LIMIT != 0), bit0 = 0 stop
module san_cnt_core #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic                  slv_reg_wren,
   input  logic [ADDR_WIDTH-1:0] axi_awaddr,
   input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
   output logic                  EXT_IRQ,
   output logic [CNT_WIDTH-1:0]  COUNT_SAN
);

   // State registers
   logic [CNT_WIDTH-1:0] limit_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 running_q;
   logic                 wren_d;
   logic                 irq_q;

   // Next-state values
   logic [CNT_WIDTH-1:0] limit_n;
   logic [CNT_WIDTH-1:0] count_n;
   logic                 running_n;
   logic                 irq_n;

   // Decoded write and terminal-count qualifiers
   logic                 wr_accept_c;
   logic                 wr_ctrl_c;
   logic                 terminal_c;
   logic [CNT_WIDTH-1:0] wr_value_c;

   // Address/data bits outside the decoded fields are intentionally ignored
   logic                 unused_bits;
   assign unused_bits = ^{axi_awaddr, S_AXI_WDATA};

   // Only the rising edge of the write strobe performs a write
   assign wr_accept_c = slv_reg_wren & ~wren_d;
   assign wr_ctrl_c   = axi_awaddr[2];
   assign wr_value_c  = S_AXI_WDATA[CNT_WIDTH-1:0];

   // Terminal compare happens before overflow, so count never wraps
   assign terminal_c  = (count_q == (limit_q - CNT_WIDTH'(1)));

   // Next-state logic: an accepted write takes priority over counting
   always_comb begin
      limit_n   = limit_q;
      count_n   = count_q;
      running_n = running_q;
      irq_n     = 1'b0;

      if (wr_accept_c) begin
         count_n = '0;
         if (wr_ctrl_c) begin
            running_n = S_AXI_WDATA[0] & (limit_q != '0);
         end else begin
            limit_n   = wr_value_c;
            running_n = (wr_value_c != '0);
         end
      end else if (running_q) begin
         if (terminal_c) begin
            count_n = '0;
            irq_n   = 1'b1;
         end else begin
            count_n = count_q + CNT_WIDTH'(1);
         end
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         limit_q   <= '0;
         count_q   <= '0;
         running_q <= 1'b0;
         wren_d    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         limit_q   <= limit_n;
         count_q   <= count_n;
         running_q <= running_n;
         wren_d    <= slv_reg_wren;
         irq_q     <= irq_n;
      end
   end

   assign EXT_IRQ   = irq_q;
   assign COUNT_SAN = count_q;

endmodule

// File: tb/tb_san_cnt_core.sv
// Self-checking bench for san_cnt_core: a cycle model pushes expected
// (irq, count) pairs as stimulus is driven; each test pops and compares them.
module tb_san_cnt_core;

   logic        clk;
   logic        rst_n;
   logic        wren;
   logic [2:0]  awaddr;
   logic [31:0] wdata;
   logic        irq;
   logic [31:0] cnt;

   typedef struct packed {
      logic        irq;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          pass_cnt;
   int          total_cnt;

   // Reference model state
   logic [31:0] m_limit;
   logic [31:0] m_count;
   logic        m_run;
   logic        m_wd;
   logic        m_irq;

   san_cnt_core #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .CNT_WIDTH(32)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .slv_reg_wren  (wren),
      .axi_awaddr    (awaddr),
      .S_AXI_WDATA   (wdata),
      .EXT_IRQ       (irq),
      .COUNT_SAN     (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic model_reset();
      m_limit = '0; m_count = '0; m_run = 1'b0; m_wd = 1'b0; m_irq = 1'b0;
   endtask

   // Drive one cycle of inputs, predict the post-edge outputs, then sample #1 after the edge
   task automatic drive_cycle(input logic wr, input logic [2:0] addr, input logic [31:0] data);
      logic acc;
      @(negedge clk);
      wren = wr; awaddr = addr; wdata = data;
      acc = wr && !m_wd;
      m_irq = 1'b0;
      if (acc) begin
         m_count = 0;
         if (addr[2]) m_run = data[0] && (m_limit != 0);
         else begin
            m_limit = data;
            m_run   = (data != 0);
         end
      end else if (m_run) begin
         if (m_count + 1 == m_limit) begin
            m_count = 0;
            m_irq   = 1'b1;
         end else begin
            m_count = m_count + 1;
         end
      end
      m_wd = wr;
      sb.push_back('{irq: m_irq, cnt: m_count});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wren = 1'b0; awaddr = '0; wdata = '0;
      model_reset();
      #9;
      total_cnt++;
      if (irq !== 1'b0 || cnt !== 32'd0)
         $display("FAIL reset_hold: irq=%0b cnt=%0d, expected irq=0 cnt=0", irq, cnt);
      else pass_cnt++;
      #1 rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         drive_cycle(1'b0, 3'd0, 32'd0);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL reset_idle cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_period();
      int first_irq = 0;
      int n_irq = 0;
      for (int i = 1; i <= 250; i++) begin
         drive_cycle(i <= 5, 3'd0, 32'd100);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL period cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (irq === 1'b1) begin
            n_irq++;
            if (first_irq == 0) first_irq = i;
         end
      end
      total_cnt++;
      if (first_irq != 101) $display("FAIL period_first_irq: cycle %0d, expected 101", first_irq);
      else pass_cnt++;
      total_cnt++;
      if (n_irq != 2) $display("FAIL period_irq_count: got %0d, expected 2", n_irq);
      else pass_cnt++;
   endtask

   task automatic test_limit1();
      int n_irq = 0;
      for (int i = 1; i <= 11; i++) begin
         drive_cycle(i == 1, 3'd0, 32'd1);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL limit1 cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (i > 1 && irq === 1'b1) n_irq++;
      end
      total_cnt++;
      if (n_irq != 10) $display("FAIL limit1_irq_count: got %0d, expected 10", n_irq);
      else pass_cnt++;
   endtask

   task automatic test_ctrl();
      int n_irq = 0;
      int first_irq = 0;
      // start LIMIT=100, stop via CTRL=0 when count==40
      for (int i = 1; i <= 42; i++) begin
         drive_cycle(i == 1 || i == 42, (i == 42) ? 3'd4 : 3'd0, (i == 42) ? 32'd0 : 32'd100);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL ctrl_run cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
      end
      for (int i = 1; i <= 150; i++) begin
         drive_cycle(1'b0, 3'd0, 32'd0);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL ctrl_stopped cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (irq === 1'b1 || cnt !== 32'd0) n_irq++;
      end
      total_cnt++;
      if (n_irq != 0) $display("FAIL ctrl_stop_quiet: %0d active cycles, expected 0", n_irq);
      else pass_cnt++;
      // restart via CTRL=1 (address 4 with low bits set, which must be ignored)
      for (int i = 1; i <= 110; i++) begin
         drive_cycle(i == 1, 3'd7, 32'hFFFF_FF01);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL ctrl_restart cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (irq === 1'b1 && first_irq == 0) first_irq = i;
      end
      total_cnt++;
      if (first_irq != 101) $display("FAIL ctrl_restart_irq: cycle %0d, expected 101", first_irq);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int first_irq = 0;
      int n_irq = 0;
      for (int i = 1; i <= 40; i++) begin
         drive_cycle(i == 1 || i == 11, 3'd0, (i == 11) ? 32'd20 : 32'd10);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL b2b cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (i == 11) begin
            total_cnt++;
            if (irq !== 1'b0 || cnt !== 32'd0)
               $display("FAIL b2b_write_wins: irq=%0b cnt=%0d, expected irq=0 cnt=0", irq, cnt);
            else pass_cnt++;
         end
         if (irq === 1'b1) begin
            n_irq++;
            if (first_irq == 0) first_irq = i;
         end
      end
      total_cnt++;
      if (first_irq != 31 || n_irq != 1)
         $display("FAIL b2b_next_irq: first=%0d count=%0d, expected first=31 count=1", first_irq, n_irq);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 6; i++) begin
         drive_cycle(i == 1, 3'd0, 32'd10);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL arst_pre cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
      end
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (irq !== 1'b0 || cnt !== 32'd0)
         $display("FAIL arst_immediate: irq=%0b cnt=%0d, expected irq=0 cnt=0", irq, cnt);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 30; i++) begin
         drive_cycle(1'b0, 3'd0, 32'd0);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL arst_idle cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
      end
      for (int i = 1; i <= 10; i++) begin
         drive_cycle(i == 1, 3'd0, 32'd3);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL arst_resume cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
      end
   endtask

   task automatic test_limit_zero();
      int active = 0;
      for (int i = 1; i <= 20; i++) begin
         drive_cycle(i == 1, 3'd0, 32'd0);
         e = sb.pop_front();
         total_cnt++;
         if (irq !== e.irq || cnt !== e.cnt)
            $display("FAIL limit0 cyc %0d: irq=%0b cnt=%0d, expected irq=%0b cnt=%0d", i, irq, cnt, e.irq, e.cnt);
         else pass_cnt++;
         if (irq === 1'b1 || cnt !== 32'd0) active++;
      end
      total_cnt++;
      if (active != 0) $display("FAIL limit0_quiet: %0d active cycles, expected 0", active);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_period();
      test_limit1();
      test_ctrl();
      test_back_to_back();
      test_limit_zero();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
